// File: rtl/ex_result_stage.sv
// Execute-to-memory boundary: registers ALU results with control, resolves branches/jumps
// into a one-cycle redirect, and buffers beats in a main + skid pair so backpressure never drops data.
module ex_result_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] ALUResult,
    input  logic            Zero,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] WriteData,
    input  logic [REGW-1:0] Rd,
    input  logic            RegWrite,
    input  logic            MemWrite,
    input  logic [1:0]      ResultSrc,
    input  logic            Branch,
    input  logic            Jump,
    input  logic            JumpReg,
    input  logic [2:0]      Funct3,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_ALUResult,
    output logic [XLEN-1:0] out_WriteData,
    output logic [XLEN-1:0] out_PCPlus4,
    output logic [REGW-1:0] out_Rd,
    output logic            out_RegWrite,
    output logic            out_MemWrite,
    output logic [1:0]      out_ResultSrc,
    output logic            PCSrc,
    output logic [XLEN-1:0] PCTarget
);

    localparam int PW = 3*XLEN + REGW + 4;

    logic [PW-1:0]   r_main;
    logic [PW-1:0]   r_skid;
    logic            r_main_valid;
    logic            r_skid_valid;
    logic            r_pcsrc;
    logic [XLEN-1:0] r_pctarget;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_target;
    logic [PW-1:0]   w_in_payload;
    logic            w_taken;
    logic            w_drain;
    logic            w_store;

    assign w_pc_plus4   = PC + XLEN'(4);
    assign w_in_payload = {ALUResult, WriteData, w_pc_plus4, Rd, RegWrite, MemWrite, ResultSrc};

    // JALR clears bit 0 of rs1+imm; everything else targets PC-relative.
    assign w_target = JumpReg ? {ALUResult[XLEN-1:1], 1'b0} : (PC + ImmExt);

    always_comb begin
        w_taken = 1'b0;
        if (Jump || JumpReg) begin
            w_taken = 1'b1;
        end else if (Branch) begin
            case (Funct3)
                3'b000:         w_taken = Zero;
                3'b001:         w_taken = !Zero;
                3'b100, 3'b110: w_taken = ALUResult[0];
                3'b101, 3'b111: w_taken = !ALUResult[0];
                default:        w_taken = 1'b0;
            endcase
        end
    end

    // in_ready depends only on registered state; during a redirect cycle the
    // wrong-path beat is swallowed, so ready is forced high and nothing is stored.
    assign in_ready = !r_skid_valid || r_pcsrc;
    assign w_drain  = r_main_valid && out_ready;
    assign w_store  = in_valid && in_ready && !r_pcsrc && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_pcsrc      <= 1'b0;
            r_pctarget   <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_pcsrc      <= 1'b0;
        end else begin
            if (!r_main_valid || w_drain) begin
                if (r_skid_valid) begin
                    r_main       <= r_skid;
                    r_main_valid <= 1'b1;
                end else if (w_store) begin
                    r_main       <= w_in_payload;
                    r_main_valid <= 1'b1;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end

            // Skid only fills when main is held; it can never be full and written at once.
            if (r_skid_valid && w_drain) begin
                r_skid_valid <= 1'b0;
            end else if (w_store && r_main_valid && !w_drain) begin
                r_skid       <= w_in_payload;
                r_skid_valid <= 1'b1;
            end

            r_pcsrc <= w_store && w_taken;
            if (w_store && w_taken) begin
                r_pctarget <= w_target;
            end
        end
    end

    assign out_valid = r_main_valid;
    assign {out_ALUResult, out_WriteData, out_PCPlus4, out_Rd,
            out_RegWrite, out_MemWrite, out_ResultSrc} = r_main;
    assign PCSrc    = r_pcsrc;
    assign PCTarget = r_pctarget;

endmodule

// File: tb/tb_ex_result_stage.sv
// Directed bench for ex_result_stage: vector table for branch/jump resolution,
// plus hand sequences for squash, backpressure, flush and async reset.
module tb_ex_result_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic [31:0] PC;
    logic [31:0] ImmExt;
    logic [31:0] WriteData;
    logic [4:0]  Rd;
    logic        RegWrite;
    logic        MemWrite;
    logic [1:0]  ResultSrc;
    logic        Branch;
    logic        Jump;
    logic        JumpReg;
    logic [2:0]  Funct3;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ALUResult;
    logic [31:0] out_WriteData;
    logic [31:0] out_PCPlus4;
    logic [4:0]  out_Rd;
    logic        out_RegWrite;
    logic        out_MemWrite;
    logic [1:0]  out_ResultSrc;
    logic        PCSrc;
    logic [31:0] PCTarget;

    ex_result_stage #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUResult(ALUResult), .Zero(Zero), .PC(PC), .ImmExt(ImmExt),
        .WriteData(WriteData), .Rd(Rd), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .ResultSrc(ResultSrc), .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg),
        .Funct3(Funct3), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ALUResult(out_ALUResult), .out_WriteData(out_WriteData),
        .out_PCPlus4(out_PCPlus4), .out_Rd(out_Rd), .out_RegWrite(out_RegWrite),
        .out_MemWrite(out_MemWrite), .out_ResultSrc(out_ResultSrc),
        .PCSrc(PCSrc), .PCTarget(PCTarget)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_target = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_valid = 0; ALUResult = 0; Zero = 0; PC = 0; ImmExt = 0; WriteData = 0;
        Rd = 0; RegWrite = 0; MemWrite = 0; ResultSrc = 0;
        Branch = 0; Jump = 0; JumpReg = 0; Funct3 = 0;
    endtask

    task automatic drive_plain(input logic [31:0] alu, input logic [31:0] pc, input logic [4:0] rd);
        clear_in();
        in_valid = 1; ALUResult = alu; PC = pc; Rd = rd; RegWrite = 1;
    endtask

    task automatic drive_beq_taken();
        clear_in();
        in_valid = 1; Branch = 1; Funct3 = 3'b000; Zero = 1; PC = 32'h100; ImmExt = 32'h20;
    endtask

    task automatic do_reset();
        clear_in();
        flush = 0; out_ready = 1; rst_n = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        step();
        last_target = 32'h0;
    endtask

    typedef struct {
        string       name;
        logic        br;
        logic        jmp;
        logic        jr;
        logic [2:0]  f3;
        logic        z;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        exp_taken;
        logic [31:0] exp_target;
        logic [31:0] exp_pc4;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{"beq_t",   1, 0, 0, 3'b000, 1, 32'h0,        32'h100,      32'h20,       5'd1,  1, 32'h120,  32'h104};
        vecs[1]  = '{"beq_nt",  1, 0, 0, 3'b000, 0, 32'h5,        32'h104,      32'h20,       5'd2,  0, 32'h0,    32'h108};
        vecs[2]  = '{"bne_t",   1, 0, 0, 3'b001, 0, 32'h5,        32'h200,      32'hFFFFFFF0, 5'd3,  1, 32'h1F0,  32'h204};
        vecs[3]  = '{"blt_t",   1, 0, 0, 3'b100, 0, 32'h1,        32'h300,      32'h8,        5'd4,  1, 32'h308,  32'h304};
        vecs[4]  = '{"bge_nt",  1, 0, 0, 3'b101, 0, 32'h1,        32'h304,      32'h8,        5'd5,  0, 32'h0,    32'h308};
        vecs[5]  = '{"bge_t",   1, 0, 0, 3'b101, 0, 32'h0,        32'h400,      32'h10,       5'd6,  1, 32'h410,  32'h404};
        vecs[6]  = '{"f3_010",  1, 0, 0, 3'b010, 1, 32'h1,        32'h404,      32'h10,       5'd7,  0, 32'h0,    32'h408};
        vecs[7]  = '{"f3_011",  1, 0, 0, 3'b011, 0, 32'h1,        32'h408,      32'h10,       5'd8,  0, 32'h0,    32'h40C};
        vecs[8]  = '{"bltu_t",  1, 0, 0, 3'b110, 0, 32'h1,        32'h500,      32'h4,        5'd9,  1, 32'h504,  32'h504};
        vecs[9]  = '{"bgeu_t",  1, 0, 0, 3'b111, 0, 32'h0,        32'h600,      32'hC,        5'd10, 1, 32'h60C,  32'h604};
        vecs[10] = '{"jal",     0, 1, 0, 3'b000, 0, 32'h0,        32'h700,      32'h100,      5'd11, 1, 32'h800,  32'h704};
        vecs[11] = '{"jalr",    0, 0, 1, 3'b000, 0, 32'h1003,     32'hFFFFFFFC, 32'h40,       5'd12, 1, 32'h1002, 32'h0};
        vecs[12] = '{"alu_op",  0, 0, 0, 3'b000, 0, 32'hDEADBEEF, 32'h10,       32'h0,        5'd13, 0, 32'h0,    32'h14};
        vecs[13] = '{"nobr_z",  0, 0, 0, 3'b000, 1, 32'h0,        32'h20,       32'h8,        5'd14, 0, 32'h0,    32'h24};
    end

    initial begin
        clear_in();
        flush = 0; out_ready = 1; rst_n = 0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_pcsrc",     {31'b0, PCSrc},     32'h0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'h1);
        chk("rst_pctarget",  PCTarget,           32'h0);
        chk("rst_out_alu",   out_ALUResult,      32'h0);
        chk("rst_out_pc4",   out_PCPlus4,        32'h0);
        do_reset();

        // Table of single beats with out_ready=1
        for (int i = 0; i < 14; i++) begin
            clear_in();
            in_valid = 1; Branch = vecs[i].br; Jump = vecs[i].jmp; JumpReg = vecs[i].jr;
            Funct3 = vecs[i].f3; Zero = vecs[i].z; ALUResult = vecs[i].alu;
            PC = vecs[i].pc; ImmExt = vecs[i].imm; Rd = vecs[i].rd; RegWrite = 1;
            chk({vecs[i].name, "_in_ready"}, {31'b0, in_ready}, 32'h1);
            step();
            clear_in();
            if (vecs[i].exp_taken) last_target = vecs[i].exp_target;
            chk({vecs[i].name, "_out_valid"}, {31'b0, out_valid}, 32'h1);
            chk({vecs[i].name, "_pcsrc"},     {31'b0, PCSrc}, {31'b0, vecs[i].exp_taken});
            chk({vecs[i].name, "_pctarget"},  PCTarget, last_target);
            chk({vecs[i].name, "_pc4"},       out_PCPlus4, vecs[i].exp_pc4);
            chk({vecs[i].name, "_alu"},       out_ALUResult, vecs[i].alu);
            chk({vecs[i].name, "_rd"},        {27'b0, out_Rd}, {27'b0, vecs[i].rd});
            step();
            chk({vecs[i].name, "_pcsrc_clr"}, {31'b0, PCSrc}, 32'h0);
            chk({vecs[i].name, "_drained"},   {31'b0, out_valid}, 32'h0);
            chk({vecs[i].name, "_tgt_hold"},  PCTarget, last_target);
        end

        // Wrong-path squash: beat offered during PCSrc is consumed and dropped
        drive_beq_taken();
        step();
        last_target = 32'h120;
        chk("sq_pcsrc", {31'b0, PCSrc}, 32'h1);
        drive_plain(32'hBAD0BAD0, 32'h104, 5'd20);
        Jump = 1;
        chk("sq_in_ready", {31'b0, in_ready}, 32'h1);
        step();
        clear_in();
        chk("sq_no_out",    {31'b0, out_valid}, 32'h0);
        chk("sq_no_redir",  {31'b0, PCSrc}, 32'h0);
        chk("sq_tgt_hold",  PCTarget, 32'h120);

        // Backpressure: A, B fill main/skid, C is held off
        out_ready = 0;
        drive_plain(32'hAAAA0001, 32'h1000, 5'd1);
        step();
        drive_plain(32'hBBBB0002, 32'h1004, 5'd2);
        chk("bp_ready_b", {31'b0, in_ready}, 32'h1);
        step();
        drive_plain(32'hCCCC0003, 32'h1008, 5'd3);
        chk("bp_ready_c0", {31'b0, in_ready}, 32'h0);
        chk("bp_out_a0",   out_ALUResult, 32'hAAAA0001);
        step();
        chk("bp_ready_c1", {31'b0, in_ready}, 32'h0);
        chk("bp_out_a1",   out_ALUResult, 32'hAAAA0001);
        chk("bp_pc4_a1",   out_PCPlus4,   32'h1004);
        out_ready = 1;
        step();
        chk("bp_out_b",   out_ALUResult, 32'hBBBB0002);
        chk("bp_valid_b", {31'b0, out_valid}, 32'h1);
        chk("bp_ready_b2", {31'b0, in_ready}, 32'h1);
        step();
        clear_in();
        chk("bp_out_c",   out_ALUResult, 32'hCCCC0003);
        chk("bp_valid_c", {31'b0, out_valid}, 32'h1);
        chk("bp_rd_c",    {27'b0, out_Rd}, 32'd3);
        step();
        chk("bp_empty",   {31'b0, out_valid}, 32'h0);

        // Flush with both entries full and a pending redirect
        out_ready = 0;
        drive_plain(32'h11111111, 32'h2000, 5'd4);
        step();
        drive_beq_taken();
        step();
        chk("fl_pcsrc_pre", {31'b0, PCSrc}, 32'h1);
        chk("fl_ready_pre", {31'b0, in_ready}, 32'h1);
        drive_plain(32'h22222222, 32'h3000, 5'd5);
        flush = 1;
        step();
        flush = 0;
        clear_in();
        chk("fl_out_valid", {31'b0, out_valid}, 32'h0);
        chk("fl_pcsrc",     {31'b0, PCSrc}, 32'h0);
        chk("fl_in_ready",  {31'b0, in_ready}, 32'h1);
        out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("fl_no_stale", {31'b0, out_valid}, 32'h0);
        end

        // Async reset mid-stream with both entries full and PCSrc=1
        out_ready = 0;
        drive_plain(32'h33333333, 32'h4000, 5'd6);
        step();
        drive_beq_taken();
        step();
        clear_in();
        chk("ar_pcsrc_pre", {31'b0, PCSrc}, 32'h1);
        #2 rst_n = 0;
        #1;
        chk("ar_out_valid", {31'b0, out_valid}, 32'h0);
        chk("ar_pcsrc",     {31'b0, PCSrc}, 32'h0);
        chk("ar_pctarget",  PCTarget, 32'h0);
        chk("ar_out_alu",   out_ALUResult, 32'h0);
        @(negedge clk);
        rst_n = 1;
        out_ready = 1;
        step();
        chk("ar_in_ready",  {31'b0, in_ready}, 32'h1);
        chk("ar_empty",     {31'b0, out_valid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_result_stage.md
# ex_result_stage

Execute-to-memory boundary stage that sits directly downstream of the `alu`. It registers ALUResult/Zero together with the instruction's control fields and resolves branches and jumps from the ALU flags. It raises a one-cycle PC redirect and buffers results in a 2-entry skid buffer, so memory-stage backpressure never drops a beat.

## Interface
- XLEN, 32, datapath width
- REGW, 5, destination register index width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- ALUResult  in  XLEN  ALU result (SUB/SLT/SLTU result for branches; rs1+imm for JALR)
- Zero  in  1  ALU zero flag
- PC  in  XLEN  instruction PC
- ImmExt  in  XLEN  sign-extended immediate
- WriteData  in  XLEN  store data
- Rd  in  REGW  destination register
- RegWrite, MemWrite  in  1 each  control
- ResultSrc  in  2  writeback select
- Branch, Jump, JumpReg  in  1 each  conditional branch / JAL / JALR
- Funct3  in  3  branch type
- flush  in  1  discard all buffered state
- out_valid  out  1  downstream beat valid
- out_ready  in  1  downstream accepts
- out_ALUResult, out_WriteData, out_PCPlus4  out  XLEN  registered payload
- out_Rd  out  REGW;  out_RegWrite, out_MemWrite  out  1;  out_ResultSrc  out  2
- PCSrc  out  1  redirect pulse
- PCTarget  out  XLEN  redirect address

## Operation
- Accept happens when in_valid & in_ready. Payload is captured with PCPlus4 = PC+4 (mod 2^XLEN).
- Storage: output register (main) plus skid register. The beat goes to main if main is empty or is being drained this cycle, otherwise to skid. When main drains, skid moves to main. Order is FIFO.
- in_ready = !skid_valid, registered. It is never combinationally dependent on out_ready.
- Taken condition:
  - Jump or JumpReg: always taken.
  - Branch, Funct3 000: Zero. 001: !Zero.
  - Branch, Funct3 100 or 110: ALUResult[0]. 101 or 111: !ALUResult[0].
  - Branch, Funct3 010 or 011: not taken.
- Target:
  - JumpReg: {ALUResult[XLEN-1:1],1'b0}.
  - Otherwise: PC+ImmExt, mod 2^XLEN.
- Redirect: an accepted taken beat sets PCSrc=1 and PCTarget=target on the next edge. PCSrc clears on the following edge, so it is exactly one cycle wide. PCTarget holds its value until the next redirect.
- Wrong-path squash: in any cycle with PCSrc=1, in_ready is forced to 1. A beat presented in that cycle is consumed and dropped. It is not stored and cannot raise a redirect.
- Flush: on the next edge, clears main_valid, skid_valid and PCSrc. Flush has priority over an accept or squash in the same cycle; that beat is dropped.
- Branches and jumps also travel down the pipe as normal beats. Their RegWrite/MemWrite are passed through unmodified.

## Timing
- Reset values (async, while rst_n=0):
  - out_valid=0, PCSrc=0, in_ready=1.
  - PCTarget and all out_* payload = 0.
  - Internal valids = 0.
- Latency: accept at edge N gives out_valid=1 and PCSrc (if taken) in cycle N+1.
- Throughput: 1 beat/cycle while out_ready=1.
- Backpressure with out_ready=0:
  - First accepted beat fills main; second fills skid.
  - in_ready falls the cycle after the skid fills.
  - in_ready rises the cycle after the skid drains.
- Simultaneous drain and accept with skid empty: main is replaced, no bubble.
- Simultaneous drain and accept with skid full: cannot occur, because in_ready=0.
- out_* are stable while out_valid & !out_ready.
- Reset asserted mid-operation: all beats and any pending redirect are lost immediately.

## Test plan
1. Reset: rst_n=0 mid-stream with both entries full and PCSrc=1 -> immediately out_valid=0, PCSrc=0, PCTarget=0. After release, in_ready=1.
2. BEQ taken: Branch=1, Funct3=000, Zero=1, PC=0x100, ImmExt=0x20 -> next cycle PCSrc=1 for one cycle, PCTarget=0x120, out_PCPlus4=0x104. The beat offered during PCSrc is dropped (no out_valid for it).
3. BLT/BGE: Funct3=100 with ALUResult=1 -> PCSrc=1. Funct3=101 with ALUResult=1 -> PCSrc=0. Funct3=010 -> PCSrc=0 regardless of flags.
4. JALR: JumpReg=1, ALUResult=0x1003, PC=0xFFFFFFFC -> PCTarget=0x1002, out_PCPlus4=0x0 (wrap).
5. Backpressure: out_ready=0, offer beats A,B,C on consecutive cycles -> A,B accepted, in_ready=0, C held. Set out_ready=1 -> outputs A,B,C in order, one per cycle, no loss or duplication.
6. Flush: both entries full, PCSrc=1, flush=1 with in_valid=1 -> next cycle out_valid=0, PCSrc=0, in_ready=1. No beat from before the flush ever appears at the output.
